// File: rtl/perf_mmio_bridge.sv
// CPU data-port bridge: serves the perf-counter MMIO window locally (read = counter value,
// write = clear strobe) and forwards every other access to the data cache unchanged.
module perf_mmio_bridge #(
    parameter logic [15:0] WIN_BASE = 16'hFFE8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_wmask,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_resp,
    output logic [15:0] cpu_rdata,
    output logic [15:0] dn_address,
    output logic        dn_read,
    output logic        dn_write,
    output logic [1:0]  dn_wmask,
    output logic [15:0] dn_wdata,
    input  logic        dn_resp,
    input  logic [15:0] dn_rdata,
    output logic [15:0] ctr_address,
    output logic        ctr_clear,
    input  logic [15:0] ctr_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CTR_RD,
        CTR_WR,
        CTR_RESP,
        MEM_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic        r_q, r_d;
    logic        w_q, w_d;
    logic [1:0]  m_q, m_d;
    logic [15:0] d_q, d_d;
    logic [15:0] rdata_q, rdata_d;

    logic req;
    logic in_win;

    assign req    = cpu_read | cpu_write;
    assign in_win = (cpu_address >= WIN_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            r_q     <= 1'b0;
            w_q     <= 1'b0;
            m_q     <= '0;
            d_q     <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            r_q     <= r_d;
            w_q     <= w_d;
            m_q     <= m_d;
            d_q     <= d_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields are captured only on acceptance; later states work from the copies.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        r_d     = r_q;
        w_d     = w_q;
        m_d     = m_q;
        d_d     = d_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    a_d = cpu_address;
                    r_d = cpu_read;
                    w_d = cpu_write;
                    m_d = cpu_wmask;
                    d_d = cpu_wdata;
                    if (in_win) begin
                        state_d = cpu_write ? CTR_WR : CTR_RD;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            CTR_RD: begin
                rdata_d = ctr_rdata;
                state_d = CTR_RESP;
            end
            CTR_WR: begin
                rdata_d = '0;
                state_d = CTR_RESP;
            end
            CTR_RESP: begin
                state_d = IDLE;
            end
            MEM_WAIT: begin
                if (dn_resp) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_resp    = 1'b0;
        cpu_rdata   = '0;
        dn_address  = '0;
        dn_read     = 1'b0;
        dn_write    = 1'b0;
        dn_wmask    = '0;
        dn_wdata    = '0;
        ctr_address = '0;
        ctr_clear   = 1'b0;
        case (state_q)
            CTR_RD: begin
                ctr_address = a_q;
            end
            CTR_WR: begin
                ctr_address = a_q;
                ctr_clear   = (m_q != 2'b00);
            end
            CTR_RESP: begin
                cpu_resp  = 1'b1;
                cpu_rdata = rdata_q;
            end
            MEM_WAIT: begin
                dn_address = a_q;
                dn_read    = r_q;
                dn_write   = w_q;
                dn_wmask   = m_q;
                dn_wdata   = d_q;
                // Cache completion is forwarded combinationally in the same cycle.
                if (dn_resp) begin
                    cpu_resp  = 1'b1;
                    cpu_rdata = dn_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
